mem_port_arbiter: RTL

- Shares the single data-side memory port (read port 1 plus the write port) between master 0 (CPU load/store unit) and master 1 (DMA/loader engine).
- Sits between the pipelined CPU, a DMA master and the mem block.
- CPU has priority by default. A starvation counter, and a locked-burst mode for master 1, prevent the DMA from being starved.
- A read-tag pipeline routes read-data-valid back to the master that issued each read.

---
 rtl/arb_pkg.sv | 18 +
 rtl/rd_tag_pipe.sv | 32 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the data-side memory port arbiter.
package arb_pkg;

    typedef enum logic {
        CPU_PRI  = 1'b0,
        DMA_LOCK = 1'b1
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    // Read tag carried alongside an outstanding mem read.
    typedef struct packed {
        logic valid;
        logic master;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that tracks which master owns each outstanding read.
module rd_tag_pipe
    import arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  rd_tag_t push,
    output rd_tag_t tail
);

    rd_tag_t stage [RD_LAT];

    // Shift tags one stage per enabled cycle; reset drops reads in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else if (en) begin
            stage[0] <= push;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the data-side mem port between the CPU (m0) and the DMA (m1).
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned BURST_MAX  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_clk_en,
    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_raddr1,
    input  logic [DATA_W-1:0] mem_rdata1,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned BC_W = $clog2(BURST_MAX + 1);

    arb_state_t      state;
    logic [SC_W-1:0] starve_cnt;
    logic [BC_W-1:0] burst_cnt;
    logic            relock_hold;
    logic            starved;
    rd_tag_t         tag_push;
    rd_tag_t         tag_tail;

    assign starved = (starve_cnt == SC_W'(STARVE_MAX));

    // Grant decision: at most one winner, none while frozen or in reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst && mem_clk_en) begin
            if (state == DMA_LOCK) begin
                m1_gnt = m1_req;
                m0_gnt = m0_req & ~m1_req;
            end else if (m0_req && m1_req) begin
                m1_gnt = starved;
                m0_gnt = ~starved;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Steer the granted master onto the mem port and tag any read it issues.
    always_comb begin
        mem_wen    = '0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_raddr1 = '0;
        tag_push   = '0;
        if (m0_gnt) begin
            if (m0_we != 4'h0) begin
                mem_wen   = m0_we;
                mem_waddr = m0_addr;
                mem_wdata = m0_wdata;
            end else begin
                mem_raddr1      = m0_addr;
                tag_push.valid  = 1'b1;
                tag_push.master = M_CPU;
            end
        end else if (m1_gnt) begin
            if (m1_we != 4'h0) begin
                mem_wen   = m1_we;
                mem_waddr = m1_addr;
                mem_wdata = m1_wdata;
            end else begin
                mem_raddr1      = m1_addr;
                tag_push.valid  = 1'b1;
                tag_push.master = M_DMA;
            end
        end
    end

    // Lock FSM plus starvation and burst counters; all frozen when mem is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CPU_PRI;
            starve_cnt  <= '0;
            burst_cnt   <= '0;
            relock_hold <= 1'b0;
        end else if (mem_clk_en) begin
            if (m1_gnt) begin
                starve_cnt <= '0;
            end else if (m1_req && !starved) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end

            if (state == CPU_PRI) begin
                // One CPU_PRI cycle must pass after a burst before re-locking.
                relock_hold <= 1'b0;
                if (m1_gnt && m1_lock && !relock_hold) begin
                    state     <= DMA_LOCK;
                    burst_cnt <= BC_W'(1);
                end
            end else begin
                if (!m1_lock || !m1_req ||
                    (m1_gnt && (burst_cnt + BC_W'(1)) == BC_W'(BURST_MAX))) begin
                    state       <= CPU_PRI;
                    burst_cnt   <= '0;
                    relock_hold <= 1'b1;
                end else if (m1_gnt) begin
                    burst_cnt <= burst_cnt + BC_W'(1);
                end
            end
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (mem_clk_en),
        .push (tag_push),
        .tail (tag_tail)
    );

    assign m0_rvalid = tag_tail.valid & (tag_tail.master == M_CPU) & mem_clk_en;
    assign m1_rvalid = tag_tail.valid & (tag_tail.master == M_DMA) & mem_clk_en;
    assign rdata     = mem_rdata1;

endmodule
